// File: rtl/systolic_feeder_if.sv
// Command, unified-buffer read port and skewed row outputs of the systolic feeder.
// The master side is the controller/buffer; the slave side is the feeder itself.
interface systolic_feeder_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned LANE_WIDTH = 8
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic [ADDR_WIDTH:0]          len;
  logic [ADDR_WIDTH-1:0]        ub_addr;
  logic [ROWS*LANE_WIDTH-1:0]   ub_dout;
  logic [ROWS*LANE_WIDTH-1:0]   a_data;
  logic [ROWS-1:0]              a_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, base_addr, len, ub_dout,
    input  ub_addr, a_data, a_valid, busy, done
  );

  modport slave (
    input  start, base_addr, len, ub_dout,
    output ub_addr, a_data, a_valid, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Read sequencer and diagonal skew stage feeding the systolic array's row inputs.
// Lane r of each buffer word is delayed r extra cycles to form the wavefront.
module systolic_feeder #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned LANE_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);
  localparam int unsigned LenW   = ADDR_WIDTH + 1;
  localparam int unsigned DrainW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                     state_q, state_d;
  logic                       accept;
  logic                       last_read;
  logic                       drain_end;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LenW-1:0]            remain_q;
  logic [DrainW-1:0]          drain_q;
  logic                       rd_valid_q;
  logic                       busy;
  logic                       done;
  logic [ROWS*LANE_WIDTH-1:0] lane_data;
  logic [ROWS-1:0]            lane_valid;

  assign accept    = (state_q == StIdle) && bus.start && (bus.len != '0);
  assign last_read = (state_q == StRead) && (remain_q == '0);
  // Last lane of the last word leaves the skew chain ROWS+1 cycles after the final read.
  assign drain_end = (state_q == StDrain) && (drain_q == DrainW'(ROWS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept)    state_d = StRead;
      StRead:  if (last_read) state_d = StDrain;
      StDrain: if (drain_end) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
    done = drain_end;
  end

  // Read address sequencing; remain_q counts addresses still to issue after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == StRead);
      if (accept) begin
        addr_q   <= bus.base_addr;
        remain_q <= bus.len - LenW'(1);
      end else if ((state_q == StRead) && (remain_q != '0)) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - LenW'(1);
      end
      if (last_read) begin
        drain_q <= '0;
      end else if (state_q == StDrain) begin
        drain_q <= drain_q + DrainW'(1);
      end
    end
  end

  // Skew chains: lane r is registered through r+1 stages; idle slots carry zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [LANE_WIDTH-1:0] d_q [r+1];
    logic [r:0]            v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= r; s++) begin
          d_q[s] <= '0;
        end
        v_q <= '0;
      end else begin
        d_q[0] <= rd_valid_q ? bus.ub_dout[r*LANE_WIDTH +: LANE_WIDTH] : '0;
        v_q[0] <= rd_valid_q;
        for (int s = 1; s <= r; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end

    assign lane_data[r*LANE_WIDTH +: LANE_WIDTH] = d_q[r];
    assign lane_valid[r]                         = v_q[r];
  end

  assign bus.ub_addr = addr_q;
  assign bus.a_data  = lane_data;
  assign bus.a_valid = lane_valid;
  assign bus.busy    = busy;
  assign bus.done    = done;
endmodule
